sram_mc: RTL and testbench

- Multi-channel, byte-maskable single-port SRAM with a round-robin request arbiter and a pipelined, tagged read return.
- Successor to the single-requester SRAM model: NUM_CH independent requesters share one array.
- Each requester gets a grant and a per-channel read-valid pulse.
- Sits between several bus masters (e.g. DMA, core) and on-chip scratch memory.

---
 rtl/sram_mc_pkg.sv | 16 +
 rtl/sram_mc_if.sv | 26 ++
 rtl/sram_rr_arb.sv | 50 +++++
 rtl/sram_mc.sv | 137 +++++++++++++
 tb/tb_sram_mc.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_mc_pkg.sv
// Shared sizing helpers for the multi-channel SRAM: tag/byte-enable widths and read-latency legality.
package sram_mc_pkg;

  function automatic int tag_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int be_w(input int bw_data);
    return bw_data / 8;
  endfunction

  function automatic bit rd_lat_ok(input int rd_lat);
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

endpackage

// File: rtl/sram_mc_if.sv
// Per-channel request bus and shared read-return bus between bus masters and sram_mc.
interface sram_mc_if #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6,
  parameter int NUM_CH  = 2
);
  logic                        i_cen;
  logic [NUM_CH-1:0]           i_req;
  logic [NUM_CH-1:0]           i_wen;
  logic [NUM_CH*BW_ADDR-1:0]   i_addr;
  logic [NUM_CH*BW_DATA-1:0]   i_data;
  logic [NUM_CH*BW_DATA/8-1:0] i_be;
  logic [NUM_CH-1:0]           o_gnt;
  logic [NUM_CH-1:0]           o_rvalid;
  logic [BW_DATA-1:0]          o_rdata;

  modport master (
    output i_cen, i_req, i_wen, i_addr, i_data, i_be,
    input  o_gnt, o_rvalid, o_rdata
  );

  modport slave (
    input  i_cen, i_req, i_wen, i_addr, i_data, i_be,
    output o_gnt, o_rvalid, o_rdata
  );
endinterface

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searching upward from ptr_q with wrap;
// ptr_q advances past the winner only on an accepted grant.
module sram_rr_arb
  import sram_mc_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int BW_TAG = tag_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_en,
  input  logic              i_accept,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [BW_TAG-1:0] o_gnt_idx
);

  logic [BW_TAG-1:0] ptr_q, ptr_d;
  logic [BW_TAG:0]   pos;
  logic              found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos = {1'b0, ptr_q} + (BW_TAG+1)'(i);
      if (pos >= (BW_TAG+1)'(NUM_CH)) pos = pos - (BW_TAG+1)'(NUM_CH);
      if (i_en && !found && i_req[pos[BW_TAG-1:0]]) begin
        found                  = 1'b1;
        o_gnt[pos[BW_TAG-1:0]] = 1'b1;
        o_gnt_idx              = pos[BW_TAG-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_accept) begin
      ptr_d = (o_gnt_idx == BW_TAG'(NUM_CH-1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_mc.sv
// Multi-channel byte-maskable SRAM: one access per cycle via round-robin grant, tagged read
// return RD_LAT (1 or 2) cycles after accept; masters hold requests until granted.
module sram_mc
  import sram_mc_pkg::*;
#(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6,
  parameter int NUM_CH  = 2,
  parameter int RD_LAT  = 1
) (
  input logic       i_clk,
  input logic       i_rstn,
  sram_mc_if.slave  bus
);

  localparam int BW_BE  = be_w(BW_DATA);
  localparam int BW_TAG = tag_w(NUM_CH);
  localparam int DEPTH  = 2**BW_ADDR;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("sram_mc: RD_LAT must be 1 or 2");
  end
  if ((BW_DATA % 8) != 0 || NUM_CH < 2 || NUM_CH > 8) begin : g_bad_geom
    $error("sram_mc: BW_DATA must be a multiple of 8 and NUM_CH in 2..8");
  end

  logic [NUM_CH-1:0]  gnt;
  logic [BW_TAG-1:0]  gnt_idx;
  logic               accept;
  logic               sel_wen;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_dat;
  logic [BW_BE-1:0]   sel_be;
  logic               rd_acc;

  logic [BW_DATA-1:0] mem_q [DEPTH];

  // Grants are forced low while reset is asserted, independent of the pointer state.
  sram_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_req     (bus.i_req),
    .i_en      (bus.i_cen & i_rstn),
    .i_accept  (accept),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx)
  );

  assign bus.o_gnt = gnt;
  assign accept    = |gnt;
  assign sel_wen   = bus.i_wen[gnt_idx];
  assign sel_addr  = bus.i_addr[int'(gnt_idx)*BW_ADDR +: BW_ADDR];
  assign sel_dat   = bus.i_data[int'(gnt_idx)*BW_DATA +: BW_DATA];
  assign sel_be    = bus.i_be[int'(gnt_idx)*BW_BE +: BW_BE];
  assign rd_acc    = accept & ~sel_wen;

  always_ff @(posedge i_clk) begin
    if (accept && sel_wen) begin
      for (int b = 0; b < BW_BE; b++) begin
        if (sel_be[b]) mem_q[sel_addr][8*b +: 8] <= sel_dat[8*b +: 8];
      end
    end
  end

  logic               s1_vld_q, s1_vld_d;
  logic [BW_TAG-1:0]  s1_tag_q, s1_tag_d;
  logic [BW_DATA-1:0] s1_dat_q, s1_dat_d;

  always_comb begin
    s1_vld_d = rd_acc;
    s1_tag_d = s1_tag_q;
    s1_dat_d = s1_dat_q;
    if (rd_acc) begin
      s1_tag_d = gnt_idx;
      s1_dat_d = mem_q[sel_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_vld_q <= 1'b0;
      s1_tag_q <= '0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_tag_q <= s1_tag_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  logic               out_vld;
  logic [BW_TAG-1:0]  out_tag;
  logic [BW_DATA-1:0] out_dat;

  if (RD_LAT == 2) begin : g_stage2
    logic               s2_vld_q;
    logic [BW_TAG-1:0]  s2_tag_q, s2_tag_d;
    logic [BW_DATA-1:0] s2_dat_q, s2_dat_d;

    always_comb begin
      s2_tag_d = s2_tag_q;
      s2_dat_d = s2_dat_q;
      if (s1_vld_q) begin
        s2_tag_d = s1_tag_q;
        s2_dat_d = s1_dat_q;
      end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        s2_vld_q <= 1'b0;
        s2_tag_q <= '0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        s2_tag_q <= s2_tag_d;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign out_vld = s2_vld_q;
    assign out_tag = s2_tag_q;
    assign out_dat = s2_dat_q;
  end else begin : g_stage1
    assign out_vld = s1_vld_q;
    assign out_tag = s1_tag_q;
    assign out_dat = s1_dat_q;
  end

  always_comb begin
    bus.o_rvalid = '0;
    if (out_vld) bus.o_rvalid[out_tag] = 1'b1;
  end

  assign bus.o_rdata = out_dat;

endmodule

// File: tb/tb_sram_mc.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance driven by the same stimulus.
module tb_sram_mc;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         cen;
  logic [1:0]   req, wen;
  logic [11:0]  addr;
  logic [127:0] data;
  logic [15:0]  be;

  int n_chk  = 0;
  int n_pass = 0;

  sram_mc_if #(.BW_DATA(64), .BW_ADDR(6), .NUM_CH(2)) b1 ();
  sram_mc_if #(.BW_DATA(64), .BW_ADDR(6), .NUM_CH(2)) b2 ();

  assign b1.i_cen = cen;  assign b2.i_cen = cen;
  assign b1.i_req = req;  assign b2.i_req = req;
  assign b1.i_wen = wen;  assign b2.i_wen = wen;
  assign b1.i_addr = addr; assign b2.i_addr = addr;
  assign b1.i_data = data; assign b2.i_data = data;
  assign b1.i_be = be;    assign b2.i_be = be;

  sram_mc #(.BW_DATA(64), .BW_ADDR(6), .NUM_CH(2), .RD_LAT(1)) u_dut1 (
    .i_clk (clk), .i_rstn (rstn), .bus (b1.slave)
  );
  sram_mc #(.BW_DATA(64), .BW_ADDR(6), .NUM_CH(2), .RD_LAT(2)) u_dut2 (
    .i_clk (clk), .i_rstn (rstn), .bus (b2.slave)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input int ch, input bit w, input logic [5:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    req[ch]           = 1'b1;
    wen[ch]           = w;
    addr[ch*6 +: 6]   = a;
    data[ch*64 +: 64] = d;
    be[ch*8 +: 8]     = m;
  endtask

  // Called and returns at posedge+1; the request is accepted at the edge inside.
  task automatic issue(input int ch, input bit w, input logic [5:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    req = '0;
    drive(ch, w, a, d, m);
    @(negedge clk);
    chk("gnt_l1", b1.o_gnt, 128'(1) << ch);
    chk("gnt_l2", b2.o_gnt, 128'(1) << ch);
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic expect_rd(input int ch, input logic [63:0] d);
    @(negedge clk);
    chk("rvalid_l1", b1.o_rvalid, 128'(1) << ch);
    chk("rdata_l1", b1.o_rdata, d);
    chk("rvalid_l2_early", b2.o_rvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rvalid_l2", b2.o_rvalid, 128'(1) << ch);
    chk("rdata_l2", b2.o_rdata, d);
    chk("rvalid_l1_single", b1.o_rvalid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  eg, ev1, ev2;
    logic [63:0] ed1, ed2;
    cen = 1'b1; req = 2'b11; wen = '0; addr = '0; data = '0; be = '0;

    // Reset state: no grant even with requests pending, outputs cleared.
    @(negedge clk);
    chk("rst_gnt_l1", b1.o_gnt, 0);
    chk("rst_gnt_l2", b2.o_gnt, 0);
    chk("rst_rvalid_l1", b1.o_rvalid, 0);
    chk("rst_rvalid_l2", b2.o_rvalid, 0);
    chk("rst_rdata_l1", b1.o_rdata, 0);
    chk("rst_rdata_l2", b2.o_rdata, 0);
    req = '0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single-channel fill then back-to-back readback.
    for (int i = 0; i < 64; i++) begin
      issue(0, 1'b1, 6'(i), 64'(i), 8'hFF);
      if (i == 0 || i == 63) chk("wr_rvalid", b1.o_rvalid, 0);
    end
    for (int i = 0; i < 66; i++) begin
      req = '0;
      if (i < 64) drive(0, 1'b0, 6'(i), 64'd0, 8'd0);
      @(negedge clk);
      ev1 = (i >= 1 && i <= 64) ? 2'b01 : 2'b00;
      ev2 = (i >= 2) ? 2'b01 : 2'b00;
      chk("seq_rvalid_l1", b1.o_rvalid, ev1);
      chk("seq_rvalid_l2", b2.o_rvalid, ev2);
      if (ev1 != 2'b00) chk("seq_rdata_l1", b1.o_rdata, 64'(i-1));
      if (ev2 != 2'b00) chk("seq_rdata_l2", b2.o_rdata, 64'(i-2));
      @(posedge clk); #1;
    end
    req = '0;
    @(negedge clk);
    chk("hold_rvalid_l2", b2.o_rvalid, 0);
    chk("hold_rdata_l1", b1.o_rdata, 64'd63);
    chk("hold_rdata_l2", b2.o_rdata, 64'd63);
    @(posedge clk); #1;

    // Byte mask, then an all-zero mask that must leave the word alone.
    issue(0, 1'b1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    issue(0, 1'b1, 6'd5, 64'h1122_3344_5566_7788, 8'h0F);
    issue(0, 1'b0, 6'd5, 64'd0, 8'd0);
    expect_rd(0, 64'hFFFF_FFFF_5566_7788);
    issue(0, 1'b1, 6'd5, 64'd0, 8'h00);
    issue(0, 1'b0, 6'd5, 64'd0, 8'd0);
    expect_rd(0, 64'hFFFF_FFFF_5566_7788);

    // Round-robin with both channels reading continuously after a reset pulse.
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req = '0;
      if (i < 6) begin
        drive(0, 1'b0, 6'd10, 64'd0, 8'd0);
        drive(1, 1'b0, 6'd20, 64'd0, 8'd0);
      end
      @(negedge clk);
      eg  = (i < 6) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ev1 = (i >= 1 && i <= 6) ? (((i-1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ev2 = (i >= 2 && i <= 7) ? (((i-2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ed1 = (ev1 == 2'b01) ? 64'd10 : 64'd20;
      ed2 = (ev2 == 2'b01) ? 64'd10 : 64'd20;
      chk("rr_gnt", b1.o_gnt, eg);
      chk("rr_rvalid_l1", b1.o_rvalid, ev1);
      chk("rr_rvalid_l2", b2.o_rvalid, ev2);
      if (ev1 != 2'b00) chk("rr_rdata_l1", b1.o_rdata, ed1);
      if (ev2 != 2'b00) chk("rr_rdata_l2", b2.o_rdata, ed2);
      @(posedge clk); #1;
    end
    req = '0;

    // Write by ch1 immediately followed by a read of the same word by ch0.
    issue(1, 1'b1, 6'd63, 64'hA5A5, 8'hFF);
    issue(0, 1'b0, 6'd63, 64'd0, 8'd0);
    expect_rd(0, 64'hA5A5);
    issue(1, 1'b0, 6'd63, 64'd0, 8'd0);
    expect_rd(1, 64'hA5A5);

    // Chip enable low: pending writes must not be granted or land in the array.
    cen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = '0;
      drive(0, 1'b1, 6'd0, 64'hDEAD_DEAD, 8'hFF);
      drive(1, 1'b1, 6'd1, 64'hBEEF_BEEF, 8'hFF);
      @(negedge clk);
      chk("cen_gnt_l1", b1.o_gnt, 0);
      chk("cen_gnt_l2", b2.o_gnt, 0);
      @(posedge clk); #1;
    end
    cen = 1'b1;
    req = '0;
    drive(0, 1'b0, 6'd0, 64'd0, 8'd0);
    drive(1, 1'b0, 6'd1, 64'd0, 8'd0);
    @(negedge clk);
    chk("cen_first_gnt", b1.o_gnt, 2'b01);
    @(posedge clk); #1;
    req = '0;
    expect_rd(0, 64'd0);
    issue(1, 1'b0, 6'd1, 64'd0, 8'd0);
    expect_rd(1, 64'd1);

    // Reset one cycle after a read accept drops the in-flight read.
    issue(0, 1'b0, 6'd7, 64'd0, 8'd0);
    rstn = 1'b0;
    drive(0, 1'b0, 6'd7, 64'd0, 8'd0);
    @(negedge clk);
    chk("mid_rst_gnt", b2.o_gnt, 0);
    chk("mid_rst_rvalid_l1", b1.o_rvalid, 0);
    chk("mid_rst_rdata_l1", b1.o_rdata, 0);
    chk("mid_rst_rvalid_l2", b2.o_rvalid, 0);
    chk("mid_rst_rdata_l2", b2.o_rdata, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid_l2", b2.o_rvalid, 0);
      chk("post_rst_rdata_l2", b2.o_rdata, 0);
      @(posedge clk); #1;
    end
    issue(0, 1'b0, 6'd5, 64'd0, 8'd0);
    expect_rd(0, 64'hFFFF_FFFF_5566_7788);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
